// File: rtl/nv_dw_lsd_pipe_if.sv
// Handshake/data bundle for nv_dw_lsd_pipe.
//   slave  : the detector's view (consumes in_*, out_ready; drives in_ready, out_*)
//   master : the environment's view (the mirror image)
// ENC_WIDTH is derived from A_WIDTH and must stay in step with the module's own derivation.
interface nv_dw_lsd_pipe_if #(
  parameter int unsigned A_WIDTH = 16
);
  localparam int unsigned ENC_WIDTH = (A_WIDTH <= 2)   ? 1 :
                                      (A_WIDTH <= 4)   ? 2 :
                                      (A_WIDTH <= 8)   ? 3 :
                                      (A_WIDTH <= 16)  ? 4 :
                                      (A_WIDTH <= 32)  ? 5 :
                                      (A_WIDTH <= 64)  ? 6 :
                                      (A_WIDTH <= 128) ? 7 : 8;

  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic                 in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [ENC_WIDTH-1:0] out_enc;
  logic [A_WIDTH-1:0]   out_dec;
  logic [A_WIDTH-1:0]   out_norm;
  logic                 out_full;
  logic                 out_mode;

  modport slave (
    input  in_valid, in_a, in_mode, out_ready,
    output in_ready, out_valid, out_enc, out_dec, out_norm, out_full, out_mode
  );

  modport master (
    output in_valid, in_a, in_mode, out_ready,
    input  in_ready, out_valid, out_enc, out_dec, out_norm, out_full, out_mode
  );
endinterface

// File: rtl/nv_dw_lsd_pipe.sv
// Two-stage leading-sign / leading-zero detector with normalising shifter.
// S1 captures the operand and mode; S2 holds shift count, one-hot position,
// pre-shifted operand, all-sign/all-zero flag and mode echo. 1 beat/cycle,
// full backpressure, ready path is combinational from out_ready only.
//
// Ports:
//   nvdla_core_clk   clock, rising edge
//   nvdla_core_rst   asynchronous active-high reset
//   io (slave)       in_valid/in_ready/in_a/in_mode, out_valid/out_ready/
//                    out_enc/out_dec/out_norm/out_full/out_mode
//   stat_clr, stat_full_cnt  only with NV_DW_LSD_PIPE_STATS_EN defined:
//                    saturating count of output transfers with out_full set;
//                    stat_clr zeroes it and wins over an increment.
module nv_dw_lsd_pipe #(
  parameter int unsigned A_WIDTH = 16
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
`ifdef NV_DW_LSD_PIPE_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_full_cnt,
`endif
  nv_dw_lsd_pipe_if.slave io
);

  localparam int unsigned ENC_WIDTH = (A_WIDTH <= 2)   ? 1 :
                                      (A_WIDTH <= 4)   ? 2 :
                                      (A_WIDTH <= 8)   ? 3 :
                                      (A_WIDTH <= 16)  ? 4 :
                                      (A_WIDTH <= 32)  ? 5 :
                                      (A_WIDTH <= 64)  ? 6 :
                                      (A_WIDTH <= 128) ? 7 : 8;

  logic                 s1_v_q, s1_v_d;
  logic                 s2_v_q, s2_v_d;
  logic [A_WIDTH-1:0]   s1_a_q;
  logic                 s1_mode_q;
  logic [ENC_WIDTH-1:0] s2_enc_q;
  logic [A_WIDTH-1:0]   s2_dec_q;
  logic [A_WIDTH-1:0]   s2_norm_q;
  logic                 s2_full_q;
  logic                 s2_mode_q;

  logic advance;
  logic in_fire;
  logic s2_load;

  // S2 can take a new beat when empty or draining this cycle; S1 follows.
  assign advance     = !s2_v_q | io.out_ready;
  assign io.in_ready = !s1_v_q | advance;
  assign in_fire     = io.in_valid & io.in_ready;
  // Only overwrite S2 data with a real beat so an emptied stage keeps its data.
  assign s2_load     = advance & s1_v_q;

  always_comb begin
    s1_v_d = s1_v_q;
    if (in_fire) begin
      s1_v_d = 1'b1;
    end else if (advance) begin
      s1_v_d = 1'b0;
    end
    s2_v_d = advance ? s1_v_q : s2_v_q;
  end

  // Detection on the S1 operand.
  logic [A_WIDTH-2:0]   diff;
  logic [ENC_WIDTH-1:0] enc_c;
  logic [A_WIDTH-1:0]   dec_c;
  logic [A_WIDTH-1:0]   norm_c;
  logic                 full_c;

  always_comb begin
    // diff[i] marks a sign change between a[i+1] and a[i].
    diff   = s1_a_q[A_WIDTH-1:1] ^ s1_a_q[A_WIDTH-2:0];
    enc_c  = ENC_WIDTH'(A_WIDTH - 1);
    full_c = 1'b1;
    dec_c  = '0;
    if (s1_mode_q) begin
      // LZD: ascending scan, so the last hit is the leading one.
      for (int unsigned i = 0; i < A_WIDTH; i++) begin
        if (s1_a_q[i]) begin
          enc_c  = ENC_WIDTH'(A_WIDTH - 1 - i);
          dec_c  = A_WIDTH'(1) << i;
          full_c = 1'b0;
        end
      end
    end else begin
      // LSD: all-sign operand marks bit 0 as the bottom of the sign run.
      dec_c = A_WIDTH'(1);
      for (int unsigned i = 0; i < A_WIDTH - 1; i++) begin
        if (diff[i]) begin
          enc_c  = ENC_WIDTH'(A_WIDTH - 2 - i);
          dec_c  = A_WIDTH'(1) << (i + 1);
          full_c = 1'b0;
        end
      end
    end
    norm_c = s1_a_q << enc_c;
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_mode_q <= 1'b0;
      s2_enc_q  <= '0;
      s2_dec_q  <= '0;
      s2_norm_q <= '0;
      s2_full_q <= 1'b0;
      s2_mode_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (in_fire) begin
        s1_a_q    <= io.in_a;
        s1_mode_q <= io.in_mode;
      end
      if (s2_load) begin
        s2_enc_q  <= enc_c;
        s2_dec_q  <= dec_c;
        s2_norm_q <= norm_c;
        s2_full_q <= full_c;
        s2_mode_q <= s1_mode_q;
      end
    end
  end

  assign io.out_valid = s2_v_q;
  assign io.out_enc   = s2_enc_q;
  assign io.out_dec   = s2_dec_q;
  assign io.out_norm  = s2_norm_q;
  assign io.out_full  = s2_full_q;
  assign io.out_mode  = s2_mode_q;

`ifdef NV_DW_LSD_PIPE_STATS_EN
  logic [15:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    stat_cnt_d = stat_cnt_q;
    if (stat_clr) begin
      stat_cnt_d = '0;
    end else if (s2_v_q && io.out_ready && s2_full_q && (stat_cnt_q != 16'hFFFF)) begin
      stat_cnt_d = stat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stat_cnt_q <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_full_cnt = stat_cnt_q;
`endif

endmodule

// File: doc/nv_dw_lsd_pipe.md
Name: nv_dw_lsd_pipe

Overview:
Parametrised, pipelined leading-sign / leading-zero detector with a normalising shifter. Mode is selected per transaction and uses a valid/ready handshake with full backpressure. Feeds float-conversion and requantisation datapaths, which need the shift count, a one-hot position and the pre-shifted operand in a single registered beat. The block has 2 register stages and sustains 1 transaction/cycle.

Parameters:
A_WIDTH, 16, operand width; legal range 2..256.
ENC_WIDTH, derived localparam, width of the shift count:
- 1 if A_WIDTH≤2; 2 if ≤4; 3 if ≤8; 4 if ≤16.
- 5 if ≤32; 6 if ≤64; 7 if ≤128; else 8.
- Not overridable.

Ports:
nvdla_core_clk  input  1  core clock; all state on rising edge.
nvdla_core_rst  input  1  asynchronous, active-high reset.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat.
in_a  input  A_WIDTH  operand.
in_mode  input  1  0 = leading-sign (LSD), 1 = leading-zero (LZD).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_enc  output  ENC_WIDTH  shift count.
out_dec  output  A_WIDTH  one-hot position.
out_norm  output  A_WIDTH  in_a << out_enc; zero-filled.
out_full  output  1  operand is all-sign (LSD) or all-zero (LZD).
out_mode  output  1  echo of in_mode.

Behaviour:
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (S1) registers in_a and in_mode. Stage 2 (S2) registers enc, dec, norm, full and mode computed from S1.
- Per-stage valid bits s1_v, s2_v; out_valid = s2_v.
  - s2 loads when (!s2_v | out_ready).
  - s1 advances under the same condition.
  - in_ready = !s1_v | (!s2_v | out_ready).
  - Combinational ready path only; no combinational valid-to-ready path through the block.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput 1/cycle. Order preserved. No drop or duplicate under any stall pattern.
- Data registers load only on advance. When a stage empties, its data is held, not cleared.
- Reset (async, any time including mid-stream): s1_v = s2_v = 0; all data registers 0. Hence out_enc = 0, out_dec = 0, out_norm = 0, out_full = 0, out_mode = 0, out_valid = 0, in_ready = 1 after release. In-flight beats are discarded.
- LSD mode, enc:
  - Find the highest i in [0, A_WIDTH-2] with a[i+1] != a[i]; enc = A_WIDTH-2-i.
  - If none exists, enc = A_WIDTH-1 and full = 1.
- LSD mode, dec: one-hot at bit A_WIDTH-1-enc, i.e. the lowest bit of the sign run.
- LZD mode, enc and dec:
  - enc = number of leading zeros; dec = one-hot at the leading-one position.
  - a == 0: enc = A_WIDTH-1, dec = 0, full = 1.
- norm = a << enc, truncated to A_WIDTH.
- A_WIDTH = 2: LSD enc is 0 or 1; all rules above still hold.
- Simultaneous output drain and input accept while full: both occur in the same cycle; the pipeline stays full.

Optional Feature:
NV_DW_LSD_PIPE_STATS_EN
- Defined:
  - Adds input port stat_clr (1 bit) and output port stat_full_cnt (16 bits).
  - stat_full_cnt counts output transfers with out_full = 1 and saturates at 16'hFFFF.
  - stat_clr zeroes the counter on the next edge; clear wins over a same-cycle increment.
  - Counter resets to 0.
- Not defined: the ports are absent and there is no counter logic. Datapath behaviour is identical in both builds.

Test Plan:
- A_WIDTH=8, LSD: in_a=8'h10 → after 2 cycles out_enc=2, out_dec=8'h20, out_norm=8'h40, out_full=0.
- LSD: in_a=8'hC0 → enc=1, dec=8'h40, norm=8'h80. LSD: in_a=8'hFF → enc=7, dec=8'h01, norm=8'h80, full=1.
- LZD: in_a=8'h10 → enc=3, dec=8'h10, norm=8'h80. LZD: in_a=8'h00 → enc=7, dec=0, norm=0, full=1.
- Backpressure: stream 6 beats back-to-back with out_ready low for cycles 3–5.
  - in_ready falls once both stages are full.
  - All 6 results emerge in order with no drop or duplicate.
  - Outputs stay stable while out_valid=1 & !out_ready.
- Reset mid-stream with 2 beats in flight: out_valid=0 and outputs 0 immediately on reset assertion. in_ready=1 after release. No stale beat emerges.
- With NV_DW_LSD_PIPE_STATS_EN defined: 3 full-operand beats → stat_full_cnt=3. stat_clr asserted in the same cycle as a 4th full beat → stat_full_cnt=0. Preload to 16'hFFFE, then 3 more full beats → stat_full_cnt=16'hFFFF.
